// File: rtl/vga_timing_pkg.sv
// Shared timing types, default 640x480@60 constants and counter-width helper
// for the VGA raster sequencer.
package vga_timing_pkg;

  // Generic porch FSM state produced by vga_axis_counter; the per-axis enums
  // below share its encoding so the top can cast between them.
  typedef enum logic [1:0] {
    AxAct   = 2'd0,
    AxFront = 2'd1,
    AxSync  = 2'd2,
    AxBack  = 2'd3
  } axis_state_t;

  typedef enum logic [1:0] {
    HAct   = 2'd0,
    HFront = 2'd1,
    HSyncp = 2'd2,
    HBack  = 2'd3
  } h_state_t;

  typedef enum logic [1:0] {
    VAct   = 2'd0,
    VFront = 2'd1,
    VSyncp = 2'd2,
    VBack  = 2'd3
  } v_state_t;

  localparam int unsigned DefHCntWid = 10;
  localparam int unsigned DefVCntWid = 10;
  localparam int unsigned DefHVis    = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVVis    = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  // True when an unsigned counter of width wid can hold max_val.
  function automatic bit cnt_fits(int unsigned wid, int unsigned max_val);
    if (wid == 0) return 1'b0;
    if (wid >= 32) return 1'b1;
    return max_val < (32'd1 << wid);
  endfunction

endpackage

// File: rtl/vga_scan_ctrl_if.sv
// Pixel-engine request/response bundle: the sequencer drives position and
// frame strobes, the engine answers with a combinational colour.
interface vga_scan_ctrl_if #(
  parameter int unsigned H_CNT_WID = 10,
  parameter int unsigned V_CNT_WID = 10
);
  logic                 NEXT_FRAME;
  logic                 H_BLANKING;
  logic [H_CNT_WID-1:0] H_CNT;
  logic [V_CNT_WID-1:0] next_V_CNT;
  logic [3:0]           r;
  logic [3:0]           g;
  logic [3:0]           b;

  modport master (
    output NEXT_FRAME,
    output H_BLANKING,
    output H_CNT,
    output next_V_CNT,
    input  r,
    input  g,
    input  b
  );

  modport slave (
    input  NEXT_FRAME,
    input  H_BLANKING,
    input  H_CNT,
    input  next_V_CNT,
    output r,
    output g,
    output b
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter 0..Tot-1 with a registered 4-state porch
// FSM (active, front porch, sync, back porch) that tracks the counter.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned CntWid = 10,
  parameter int unsigned Vis    = 640,
  parameter int unsigned Fp     = 16,
  parameter int unsigned Sync   = 96,
  parameter int unsigned Bp     = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              adv_i,
  output logic [CntWid-1:0] cnt_o,
  output axis_state_t       state_o,
  output logic              wrap_o
);

  localparam int unsigned Tot        = Vis + Fp + Sync + Bp;
  localparam int unsigned FrontStart = Vis;
  localparam int unsigned SyncStart  = Vis + Fp;
  localparam int unsigned BackStart  = Vis + Fp + Sync;
  localparam logic [CntWid-1:0] CntMax = CntWid'(Tot - 1);

  if (!cnt_fits(CntWid, Tot - 1)) begin : g_bad_width
    $error("vga_axis_counter: CntWid=%0d cannot hold %0d", CntWid, Tot - 1);
  end

  logic [CntWid-1:0] cnt_q;
  logic [CntWid-1:0] cnt_inc;
  axis_state_t       state_q;

  assign cnt_inc = cnt_q + 1'b1;

  // State is chosen from the range of the next count, so zero-length
  // porches simply skip their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= AxAct;
    end else if (adv_i) begin
      if (cnt_q == CntMax) begin
        cnt_q   <= '0;
        state_q <= AxAct;
      end else begin
        cnt_q <= cnt_inc;
        if (32'(cnt_inc) >= BackStart) begin
          state_q <= AxBack;
        end else if (32'(cnt_inc) >= SyncStart) begin
          state_q <= AxSync;
        end else if (32'(cnt_inc) >= FrontStart) begin
          state_q <= AxFront;
        end else begin
          state_q <= AxAct;
        end
      end
    end
  end

  assign cnt_o   = cnt_q;
  assign state_o = state_q;
  // Terminal count: the counter wraps on the next advance.
  assign wrap_o  = (cnt_q == CntMax);

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster scan sequencer: horizontal/vertical timing, pixel-engine
// requests, and blanked colour registered in step with the syncs.
module vga_scan_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_CNT_WID = DefHCntWid,
  parameter int unsigned V_CNT_WID = DefVCntWid,
  parameter int unsigned H_VIS     = DefHVis,
  parameter int unsigned H_FP      = DefHFp,
  parameter int unsigned H_SYNC    = DefHSync,
  parameter int unsigned H_BP      = DefHBp,
  parameter int unsigned V_VIS     = DefVVis,
  parameter int unsigned V_FP      = DefVFp,
  parameter int unsigned V_SYNC    = DefVSync,
  parameter int unsigned V_BP      = DefVBp
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pix_en,
  vga_scan_ctrl_if.master        pixIf,
  output logic [3:0]             vga_r,
  output logic [3:0]             vga_g,
  output logic [3:0]             vga_b,
  output logic                   vga_hs,
  output logic                   vga_vs
);

  localparam logic [H_CNT_WID-1:0] HLastVis = H_CNT_WID'(H_VIS - 1);

  logic [H_CNT_WID-1:0] h_cnt;
  logic [V_CNT_WID-1:0] v_cnt;
  axis_state_t          h_axis;
  axis_state_t          v_axis;
  h_state_t             h_state;
  v_state_t             v_state;
  logic                 h_last;
  logic                 v_last;
  logic                 h_wrap;
  logic                 front_entry;
  logic                 visible;

  logic [V_CNT_WID-1:0] next_v_q;
  logic                 next_frame_q;
  logic [11:0]          rgb_q;
  logic                 hs_q;
  logic                 vs_q;

  assign h_wrap = pix_en && h_last;

  vga_axis_counter #(
    .CntWid (H_CNT_WID),
    .Vis    (H_VIS),
    .Fp     (H_FP),
    .Sync   (H_SYNC),
    .Bp     (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (pix_en),
    .cnt_o   (h_cnt),
    .state_o (h_axis),
    .wrap_o  (h_last)
  );

  vga_axis_counter #(
    .CntWid (V_CNT_WID),
    .Vis    (V_VIS),
    .Fp     (V_FP),
    .Sync   (V_SYNC),
    .Bp     (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .adv_i   (h_wrap),
    .cnt_o   (v_cnt),
    .state_o (v_axis),
    .wrap_o  (v_last)
  );

  assign h_state = h_state_t'(h_axis);
  assign v_state = v_state_t'(v_axis);

  // Last visible pixel of the line: the engine is told the upcoming line here.
  assign front_entry = pix_en && (h_cnt == HLastVis);
  assign visible     = (h_state == HAct) && (v_state == VAct);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_v_q     <= '0;
      next_frame_q <= 1'b0;
    end else begin
      // Cleared on every clock so the strobe never outlives one cycle.
      next_frame_q <= front_entry && v_last;
      if (front_entry) begin
        next_v_q <= v_last ? '0 : v_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_q <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_en) begin
      rgb_q <= visible ? {pixIf.r, pixIf.g, pixIf.b} : 12'h000;
      hs_q  <= (h_state != HSyncp);
      vs_q  <= (v_state != VSyncp);
    end
  end

  assign pixIf.NEXT_FRAME = next_frame_q;
  assign pixIf.H_BLANKING = (h_state != HAct);
  assign pixIf.H_CNT      = h_cnt;
  assign pixIf.next_V_CNT = next_v_q;

  assign vga_r  = rgb_q[11:8];
  assign vga_g  = rgb_q[7:4];
  assign vga_b  = rgb_q[3:0];
  assign vga_hs = hs_q;
  assign vga_vs = vs_q;

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Raster scan sequencer for the pixel path. It generates VGA horizontal and vertical timing and drives the pixel-interface request signals consumed by the pixel engine (frame strobe, horizontal blanking, horizontal counter, next-line counter). It registers the engine's returned colour, blanks it outside the visible area and aligns it with the sync outputs. It sits between the top-level clock/reset and the VGA pins, with the pixel engine hung off its pixIf_* ports.

## Interface
Parameters:
- H_CNT_WID, 10, width of horizontal counter; must hold H_VIS+H_FP+H_SYNC+H_BP-1
- V_CNT_WID, 10, width of vertical counter; must hold V_VIS+V_FP+V_SYNC+V_BP-1
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- pix_en  in  1  pixel-clock enable; all state advances only when high
- pixIf_NEXT_FRAME  out  1  one-enable-cycle pulse announcing frame start
- pixIf_H_BLANKING  out  1  high while horizontal counter is outside visible area
- pixIf_H_CNT  out  H_CNT_WID  current horizontal position
- pixIf_next_V_CNT  out  V_CNT_WID  line to be displayed next
- pixIf_r, pixIf_g, pixIf_b  in  4 each  colour from pixel engine (combinational on the above)
- vga_r, vga_g, vga_b  out  4 each  registered, blanked colour
- vga_hs, vga_vs  out  1 each  sync, active-low, registered

## Operation
- Horizontal FSM, states H_ACT, H_FRONT, H_SYNCP, H_BACK, driven by h_cnt 0..H_TOT-1 (H_TOT = sum of H params).
  - Transitions occur at h_cnt = H_VIS, H_VIS+H_FP, H_VIS+H_FP+H_SYNC.
  - h_cnt wraps H_TOT-1 -> 0, returning the FSM to H_ACT.
- Vertical FSM, states V_ACT, V_FRONT, V_SYNCP, V_BACK, driven by v_cnt 0..V_TOT-1.
  - v_cnt increments only when h_cnt wraps; wraps V_TOT-1 -> 0.
- pixIf_H_CNT = h_cnt. pixIf_H_BLANKING = (horizontal state != H_ACT).
- pixIf_next_V_CNT register:
  - Loads (v_cnt+1) mod V_TOT on the enabled cycle where h_cnt goes H_VIS-1 -> H_VIS (entry to H_FRONT).
  - The engine therefore sees the upcoming line for the whole blanking interval and the following visible line.
- pixIf_NEXT_FRAME pulses high for the same enabled cycle in which pixIf_next_V_CNT loads 0, i.e. on the last line (v_cnt = V_TOT-1).
- Visible (pre-register) = H_ACT and V_ACT.
- vga_rgb <= visible ? {pixIf_r,pixIf_g,pixIf_b} : 0.
- vga_hs <= !(H_SYNCP). vga_vs <= !(V_SYNCP).
- pix_en low: counters, FSMs, next_V_CNT and output registers hold; NEXT_FRAME is forced low.

## Timing
- Reset values:
  - Counters and next_V_CNT: h_cnt=0, v_cnt=0, pixIf_next_V_CNT=0.
  - FSMs: H_ACT/V_ACT.
  - Outputs: pixIf_H_BLANKING=0, pixIf_NEXT_FRAME=0, vga_rgb=0, vga_hs=1, vga_vs=1.
- Reset deassertion mid-frame restarts at line 0, pixel 0. No pulse is emitted for the interrupted frame.
- Colour latency: one enabled cycle from pixIf_H_CNT to vga_rgb. Sync outputs share this latency so they stay aligned.
- Line period: H_TOT enabled cycles. Frame period: H_TOT·V_TOT enabled cycles. NEXT_FRAME occurs exactly once per frame.
- Counter widths are unsigned. Parameters violating the width rule are illegal and are rejected by an elaboration-time assertion.
- Line-end and frame-end events on the same cycle: v_cnt wrap and h_cnt wrap occur together. The next_V_CNT load happens earlier in the line, so there is no conflict.

## Structure
- Shared package vga_timing_pkg:
  - h_state_t and v_state_t enums.
  - Default 640x480@60 timing constants.
  - A width-check function.
- One sub-module, vga_axis_counter: counter plus 4-state porch FSM with a wrap output. It is instantiated twice (horizontal, and vertical with advance = horizontal wrap).

## Test plan
- Reset, 2 frames, pix_en=1 -> NEXT_FRAME pulses exactly every 420000 cycles; first pulse at cycle 524·800+640 after reset release.
- Line scan -> H_BLANKING rises at h_cnt=640; vga_hs low for cycles at h_cnt 657..752 (one-cycle delay); next_V_CNT changes from 0 to 1 at h_cnt=640 on line 0.
- Frame wrap -> on line 524, next_V_CNT loads 0 together with NEXT_FRAME; vga_vs low during lines 490..491 (delayed one cycle).
- Colour path: engine stub returns constant 12'hFFF -> vga_rgb=FFF only for h_cnt 1..640 visible-line cycles (delayed), 0 in all porches and lines ≥480.
- pix_en toggled 1/0 alternately -> all outputs hold on disabled cycles; frame period doubles to 840000 clk cycles; NEXT_FRAME width stays one cycle.
- rst asserted asynchronously at line 300, pixel 100 -> outputs take reset values immediately, without waiting for a clock edge; after release, scan restarts at 0/0.
